// File: rtl/iq_dispatch_if.sv
// rtl/iq_dispatch_if.sv - issue-queue element types, shared decode and dispatch bus
package iq_dispatch_pkg;

  localparam int IQ_ADDR = 4;

  typedef enum logic [2:0] {
    FU_ALU = 3'd0,
    FU_MUL = 3'd1,
    FU_LSU = 3'd2,
    FU_BRU = 3'd3,
    FU_CSR = 3'd4,
    FU_ILL = 3'd5
  } fu_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    fu_t         fu;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rd_we;
    logic        rs1_re;
    logic        rs2_re;
    logic [31:0] imm;
  } ISSUE_QUEUE_ELEMENT;

  // RV32IM-style field extraction; anything unrecognised is tagged FU_ILL
  function automatic ISSUE_QUEUE_ELEMENT decode_inst(input logic [31:0] pc,
                                                     input logic [31:0] inst);
    ISSUE_QUEUE_ELEMENT e;
    e        = '0;
    e.pc     = pc;
    e.inst   = inst;
    e.rd     = inst[11:7];
    e.rs1    = inst[19:15];
    e.rs2    = inst[24:20];
    e.fu     = FU_ILL;
    case (inst[6:0])
      7'b0110111, 7'b0010111: begin
        e.fu    = FU_ALU;
        e.rd_we = 1'b1;
        e.imm   = {inst[31:12], 12'b0};
      end
      7'b1101111: begin
        e.fu    = FU_BRU;
        e.rd_we = 1'b1;
        e.imm   = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      7'b1100111: begin
        e.fu     = FU_BRU;
        e.rd_we  = 1'b1;
        e.rs1_re = 1'b1;
        e.imm    = {{20{inst[31]}}, inst[31:20]};
      end
      7'b1100011: begin
        e.fu     = FU_BRU;
        e.rs1_re = 1'b1;
        e.rs2_re = 1'b1;
        e.imm    = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      7'b0000011: begin
        e.fu     = FU_LSU;
        e.rd_we  = 1'b1;
        e.rs1_re = 1'b1;
        e.imm    = {{20{inst[31]}}, inst[31:20]};
      end
      7'b0100011: begin
        e.fu     = FU_LSU;
        e.rs1_re = 1'b1;
        e.rs2_re = 1'b1;
        e.imm    = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      end
      7'b0010011: begin
        e.fu     = FU_ALU;
        e.rd_we  = 1'b1;
        e.rs1_re = 1'b1;
        e.imm    = {{20{inst[31]}}, inst[31:20]};
      end
      7'b0110011: begin
        e.fu     = (inst[31:25] == 7'b0000001) ? FU_MUL : FU_ALU;
        e.rd_we  = 1'b1;
        e.rs1_re = 1'b1;
        e.rs2_re = 1'b1;
      end
      7'b1110011: begin
        e.fu     = FU_CSR;
        e.rd_we  = 1'b1;
        e.rs1_re = ~inst[14];
        e.imm    = {20'b0, inst[31:20]};
      end
      default: e.fu = FU_ILL;
    endcase
    // x0 is never a real destination
    if (e.rd == 5'd0) e.rd_we = 1'b0;
    return e;
  endfunction

endpackage

interface iq_dispatch_if #(parameter int BUF_DEPTH = 4);
  import iq_dispatch_pkg::*;

  logic [1:0]                  fetch_valid;
  logic [1:0][31:0]            fetch_inst;
  logic [1:0][31:0]            fetch_pc;
  logic                        fetch_ready;
  logic                        flush;
  logic [IQ_ADDR-1:0]          iq_size_left;
  ISSUE_QUEUE_ELEMENT [1:0]    in_data;
  logic [1:0]                  in_data_number;
  logic [$clog2(BUF_DEPTH):0]  buf_count;

  modport slave (
    input  fetch_valid, fetch_inst, fetch_pc, flush, iq_size_left,
    output fetch_ready, in_data, in_data_number, buf_count
  );

  modport master (
    output fetch_valid, fetch_inst, fetch_pc, flush, iq_size_left,
    input  fetch_ready, in_data, in_data_number, buf_count
  );

endinterface

// File: rtl/iq_dispatch.sv
// rtl/iq_dispatch.sv - fetch buffer that decodes and pushes up to two instructions per cycle into the issue queue
module iq_dispatch
  import iq_dispatch_pkg::*;
#(
  parameter int BUF_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  iq_dispatch_if.slave  bus
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   pc_mem   [BUF_DEPTH];
  logic [31:0]   inst_mem [BUF_DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  logic [PW-1:0] head1;
  logic [PW-1:0] tail1;
  logic          ready;
  logic [1:0]    acc_n;
  logic [1:0]    push_n;

  assign head1 = head + 1'b1;
  assign tail1 = tail + 1'b1;

  // Ready looks only at registered occupancy, so iq_size_left never reaches fetch_ready
  assign ready = (count <= CW'(BUF_DEPTH - 2));

  always_comb begin
    acc_n = 2'd0;
    if (!rst && !bus.flush && ready) begin
      case (bus.fetch_valid)
        2'b01:   acc_n = 2'd1;
        2'b11:   acc_n = 2'd2;
        default: acc_n = 2'd0;
      endcase
    end
  end

  always_comb begin
    push_n = 2'd0;
    if (!rst && !bus.flush) begin
      if (count >= CW'(2) && bus.iq_size_left >= IQ_ADDR'(2))
        push_n = 2'd2;
      else if (count != '0 && bus.iq_size_left != '0)
        push_n = 2'd1;
    end
  end

  always_comb begin
    bus.in_data = '0;
    if (push_n != 2'd0)
      bus.in_data[0] = decode_inst(pc_mem[head], inst_mem[head]);
    if (push_n == 2'd2)
      bus.in_data[1] = decode_inst(pc_mem[head1], inst_mem[head1]);
  end

  assign bus.in_data_number = push_n;
  assign bus.fetch_ready    = ready;
  assign bus.buf_count      = count;

  always_ff @(posedge clk) begin
    if (acc_n != 2'd0) begin
      pc_mem[tail]   <= bus.fetch_pc[0];
      inst_mem[tail] <= bus.fetch_inst[0];
    end
    if (acc_n == 2'd2) begin
      pc_mem[tail1]   <= bus.fetch_pc[1];
      inst_mem[tail1] <= bus.fetch_inst[1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(push_n);
      tail  <= tail + PW'(acc_n);
      count <= count + CW'(acc_n) - CW'(push_n);
    end
  end

endmodule

// File: tb/tb_iq_dispatch.sv
// tb/tb_iq_dispatch.sv - queue-model scoreboard bench for iq_dispatch
module tb_iq_dispatch;
  import iq_dispatch_pkg::*;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  iq_dispatch_if #(.BUF_DEPTH(DEPTH)) bus ();

  iq_dispatch #(.BUF_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  ent_t q[$];

  logic [1:0]         last_n;
  logic [31:0]        last_pc0;
  logic [31:0]        last_pc1;
  ISSUE_QUEUE_ELEMENT last_d1;
  logic               last_ready;
  logic [2:0]         last_count;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_el(input string name, input ISSUE_QUEUE_ELEMENT act, input ISSUE_QUEUE_ELEMENT exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got pc=%h inst=%h (%h) expected pc=%h inst=%h (%h) at %0t",
               name, act.pc, act.inst, act, exp.pc, exp.inst, exp, $time);
    end
  endtask

  // One cycle: drive, compare against the queue model, then advance the model at the edge
  task automatic step(input logic r, input logic f, input logic [1:0] v,
                      input logic [31:0] p0, input logic [31:0] i0,
                      input logic [31:0] p1, input logic [31:0] i1,
                      input logic [3:0] sl, output logic acc);
    int occ, n, a;
    logic exp_ready;
    ISSUE_QUEUE_ELEMENT e0, e1;
    @(negedge clk);
    rst              = r;
    bus.flush        = f;
    bus.fetch_valid  = v;
    bus.fetch_pc[0]  = p0;
    bus.fetch_inst[0] = i0;
    bus.fetch_pc[1]  = p1;
    bus.fetch_inst[1] = i1;
    bus.iq_size_left = sl;
    #1;
    occ = q.size();
    exp_ready = (DEPTH - occ) >= 2;
    n = 0;
    if (!r && !f) begin
      n = occ;
      if (n > 2) n = 2;
      if (n > int'(sl)) n = int'(sl);
    end
    e0 = '0;
    e1 = '0;
    if (n >= 1) e0 = decode_inst(q[0].pc, q[0].inst);
    if (n == 2) e1 = decode_inst(q[1].pc, q[1].inst);
    a = 0;
    if (!r && !f && exp_ready && (v == 2'b01 || v == 2'b11)) a = (v == 2'b11) ? 2 : 1;

    last_n     = bus.in_data_number;
    last_pc0   = bus.in_data[0].pc;
    last_pc1   = bus.in_data[1].pc;
    last_d1    = bus.in_data[1];
    last_ready = bus.fetch_ready;
    last_count = bus.buf_count;

    chk("in_data_number", 64'(bus.in_data_number), 64'(n));
    chk_el("in_data0", bus.in_data[0], e0);
    chk_el("in_data1", bus.in_data[1], e1);
    if (!r) begin
      chk("fetch_ready", 64'(bus.fetch_ready), 64'(exp_ready));
      chk("buf_count", 64'(bus.buf_count), 64'(occ));
    end
    acc = (a != 0);

    @(posedge clk);
    if (r || f) begin
      q.delete();
    end else begin
      for (int k = 0; k < n; k++) void'(q.pop_front());
      if (a >= 1) q.push_back('{pc: p0, inst: i0});
      if (a == 2) q.push_back('{pc: p1, inst: i1});
    end
  endtask

  task automatic idle(input logic [3:0] sl);
    logic acc;
    step(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, sl, acc);
  endtask

  function automatic logic [31:0] mk_inst(input logic [31:0] pc);
    logic [31:0] w;
    w = {pc[11:0], 5'd1, 3'b000, pc[6:2], 7'b0010011};
    return w;
  endfunction

  initial begin
    logic acc;
    logic [31:0] pc_next;
    logic pending;
    logic [1:0] pv;
    logic [31:0] pp0, pp1;

    bus.flush = 1'b0;
    bus.fetch_valid = 2'b00;
    bus.fetch_pc = '0;
    bus.fetch_inst = '0;
    bus.iq_size_left = '0;

    step(1'b1, 1'b0, 2'b00, 0, 0, 0, 0, 4'd8, acc);
    step(1'b1, 1'b0, 2'b11, 0, 0, 0, 0, 4'd8, acc);
    idle(4'd8);
    chk("reset_ready", 64'(last_ready), 64'd1);
    chk("reset_count", 64'(last_count), 64'd0);
    chk("reset_n", 64'(last_n), 64'd0);

    // 2-wide streaming with a roomy queue
    step(1'b0, 1'b0, 2'b11, 32'h0, mk_inst(32'h0), 32'h4, mk_inst(32'h4), 4'd8, acc);
    chk("stream_acc0", 64'(acc), 64'd1);
    step(1'b0, 1'b0, 2'b11, 32'h8, mk_inst(32'h8), 32'hC, mk_inst(32'hC), 4'd8, acc);
    chk("stream_n0", 64'(last_n), 64'd2);
    chk("stream_pc0", 64'(last_pc0), 64'h0);
    chk("stream_pc1", 64'(last_pc1), 64'h4);
    idle(4'd8);
    chk("stream_pc2", 64'(last_pc0), 64'h8);
    chk("stream_pc3", 64'(last_pc1), 64'hC);
    idle(4'd8);

    // back-pressure: fill to 3, then drain one per cycle
    step(1'b0, 1'b0, 2'b01, 32'h200, mk_inst(32'h200), 0, 0, 4'd0, acc);
    step(1'b0, 1'b0, 2'b11, 32'h204, mk_inst(32'h204), 32'h208, mk_inst(32'h208), 4'd0, acc);
    step(1'b0, 1'b0, 2'b11, 32'h20C, mk_inst(32'h20C), 32'h210, mk_inst(32'h210), 4'd0, acc);
    chk("bp_count3", 64'(last_count), 64'd3);
    chk("bp_ready0", 64'(last_ready), 64'd0);
    chk("bp_noacc", 64'(acc), 64'd0);
    step(1'b0, 1'b0, 2'b11, 32'h20C, mk_inst(32'h20C), 32'h210, mk_inst(32'h210), 4'd8, acc);
    chk("bp_ready0_push2", 64'(last_ready), 64'd0);
    chk("bp_n2_at_3", 64'(last_n), 64'd2);
    step(1'b0, 1'b0, 2'b11, 32'h20C, mk_inst(32'h20C), 32'h210, mk_inst(32'h210), 4'd1, acc);
    chk("bp_ready1", 64'(last_ready), 64'd1);
    chk("bp_n1", 64'(last_n), 64'd1);
    chk("bp_pc208", 64'(last_pc0), 64'h208);
    repeat (3) idle(4'd1);
    idle(4'd8);

    // single-slot packets
    step(1'b0, 1'b0, 2'b01, 32'h100, mk_inst(32'h100), 0, 0, 4'd2, acc);
    step(1'b0, 1'b0, 2'b01, 32'h104, mk_inst(32'h104), 0, 0, 4'd2, acc);
    chk("single_n", 64'(last_n), 64'd1);
    chk("single_el1_zero", 64'(last_d1 == '0), 64'd1);
    step(1'b0, 1'b0, 2'b01, 32'h108, mk_inst(32'h108), 0, 0, 4'd2, acc);
    chk("single_pc104", 64'(last_pc0), 64'h104);
    idle(4'd2);
    idle(4'd2);

    // pointer wrap across index 3 -> 0
    step(1'b0, 1'b1, 2'b00, 0, 0, 0, 0, 4'd0, acc);
    step(1'b0, 1'b0, 2'b01, 32'h300, mk_inst(32'h300), 0, 0, 4'd0, acc);
    step(1'b0, 1'b0, 2'b11, 32'h304, mk_inst(32'h304), 32'h308, mk_inst(32'h308), 4'd0, acc);
    idle(4'd1);
    chk("wrap_pc300", 64'(last_pc0), 64'h300);
    step(1'b0, 1'b0, 2'b11, 32'h30C, mk_inst(32'h30C), 32'h310, mk_inst(32'h310), 4'd0, acc);
    chk("wrap_acc", 64'(acc), 64'd1);
    idle(4'd8);
    chk("wrap_pc304", 64'(last_pc0), 64'h304);
    idle(4'd8);
    chk("wrap_pc30c", 64'(last_pc0), 64'h30C);
    chk("wrap_pc310", 64'(last_pc1), 64'h310);

    // flush with full buffer, valid fetch and queue room
    step(1'b0, 1'b0, 2'b01, 32'h380, mk_inst(32'h380), 0, 0, 4'd0, acc);
    step(1'b0, 1'b0, 2'b11, 32'h384, mk_inst(32'h384), 32'h388, mk_inst(32'h388), 4'd0, acc);
    step(1'b0, 1'b1, 2'b11, 32'h400, mk_inst(32'h400), 32'h404, mk_inst(32'h404), 4'd4, acc);
    chk("flush_count3", 64'(last_count), 64'd3);
    chk("flush_n0", 64'(last_n), 64'd0);
    step(1'b0, 1'b0, 2'b11, 32'h500, mk_inst(32'h500), 32'h504, mk_inst(32'h504), 4'd4, acc);
    chk("flush_count0", 64'(last_count), 64'd0);
    idle(4'd4);
    chk("postflush_pc0", 64'(last_pc0), 64'h500);
    chk("postflush_pc1", 64'(last_pc1), 64'h504);

    // illegal 2'b10 pattern is ignored
    step(1'b0, 1'b0, 2'b01, 32'h600, mk_inst(32'h600), 0, 0, 4'd0, acc);
    repeat (3) begin
      step(1'b0, 1'b0, 2'b10, 32'h700, mk_inst(32'h700), 32'h704, mk_inst(32'h704), 4'd0, acc);
      chk("illegal_count", 64'(last_count), 64'd1);
    end
    idle(4'd8);

    // reset mid-stream
    step(1'b0, 1'b0, 2'b11, 32'h800, mk_inst(32'h800), 32'h804, mk_inst(32'h804), 4'd0, acc);
    step(1'b1, 1'b0, 2'b11, 32'h808, mk_inst(32'h808), 32'h80C, mk_inst(32'h80C), 4'd8, acc);
    chk("rst_mid_n0", 64'(last_n), 64'd0);
    idle(4'd8);
    chk("rst_mid_count0", 64'(last_count), 64'd0);

    // random back-pressure with a holding fetch source
    pc_next = 32'h1000;
    pending = 1'b0;
    pv = 2'b00;
    pp0 = '0;
    pp1 = '0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      logic f, r;
      logic [3:0] sl;
      if (!pending) begin
        case ($urandom_range(0, 9))
          0, 1:    pv = 2'b00;
          2, 3, 4: pv = 2'b01;
          5:       pv = 2'b10;
          default: pv = 2'b11;
        endcase
        pp0 = pc_next;
        pp1 = pc_next + 32'd4;
        pending = (pv == 2'b01 || pv == 2'b11);
        if (pending) pc_next = pc_next + ((pv == 2'b11) ? 32'd8 : 32'd4);
      end
      f  = ($urandom_range(0, 63) == 0);
      r  = ($urandom_range(0, 999) == 0);
      sl = 4'($urandom_range(0, 4));
      step(r, f, pv, pp0, mk_inst(pp0) ^ 32'($urandom_range(0, 1) << 25),
           pp1, mk_inst(pp1), sl, acc);
      if (acc || f || r) pending = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
